packet_depacketizer_sc: RTL and testbench

- Single-clock receive stage directly downstream of the wide packetizer.
- Arbitrates the packet link by driving the packetizer's grant, and checks the start and header packets.
- Reassembles PAYLOAD_WIDTH/PACKET_WIDTH data packets (LSB packet first) into one payload word.
- Presents the payload on a valid/ready interface toward the L2-side consumer; pulses packet_received_o per delivered payload to feed the packetizer's throttle counter.

---
 rtl/packet_link_pkg.sv | 39 +++
 rtl/packet_depacketizer_sc_if.sv | 26 ++
 rtl/packet_depacketizer_sc.sv | 138 +++++++++++++
 tb/tb_packet_depacketizer_sc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_link_pkg.sv
// rtl/packet_link_pkg.sv - shared packet link types, field positions and size helpers
package packet_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_HDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    // Bit positions inside the start packet
    localparam int VALID_BIT = 0;
    localparam int ID_BIT    = 1;

    // err_code values
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_START = 2'd1;
    localparam logic [1:0] ERR_HDR   = 2'd2;

    function automatic int n_data(input int payload_width, input int packet_width);
        return payload_width / packet_width;
    endfunction

    // Header value: data packets plus the header itself
    function automatic int n_pkts(input int payload_width, input int packet_width);
        return n_data(payload_width, packet_width) + 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/packet_depacketizer_sc_if.sv
// rtl/packet_depacketizer_sc_if.sv - packet link and payload handshake bundle
interface packet_depacketizer_sc_if #(
    parameter int PAYLOAD_WIDTH = 512,
    parameter int PACKET_WIDTH  = 16
);
    logic                     packet_req_i;
    logic                     lock_i;
    logic [PACKET_WIDTH-1:0]  packet_i;
    logic                     packet_grant_o;
    logic                     payload_valid_o;
    logic [PAYLOAD_WIDTH-1:0] payload_o;
    logic                     payload_ready_i;
    logic                     packet_received_o;

    // Packetizer and consumer side
    modport master (
        output packet_req_i, lock_i, packet_i, payload_ready_i,
        input  packet_grant_o, payload_valid_o, payload_o, packet_received_o
    );

    // Depacketizer side
    modport slave (
        input  packet_req_i, lock_i, packet_i, payload_ready_i,
        output packet_grant_o, payload_valid_o, payload_o, packet_received_o
    );
endinterface

// File: rtl/packet_depacketizer_sc.sv
// rtl/packet_depacketizer_sc.sv - grants the packet link, checks start/header, reassembles payload
module packet_depacketizer_sc
    import packet_link_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 512,
    parameter int PACKET_WIDTH  = 16,
    parameter int ID            = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    packet_depacketizer_sc_if.slave   bus,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);

    localparam int N_DATA = n_data(PAYLOAD_WIDTH, PACKET_WIDTH);
    localparam int N_PKTS = n_pkts(PAYLOAD_WIDTH, PACKET_WIDTH);
    localparam int CNT_W  = (clog2(N_DATA) > 0) ? clog2(N_DATA) : 1;

    localparam logic [PACKET_WIDTH-1:0] START_WORD =
        PACKET_WIDTH'((ID & 1) << ID_BIT) | PACKET_WIDTH'(1 << VALID_BIT);
    localparam logic [PACKET_WIDTH-1:0] HDR_WORD  = PACKET_WIDTH'(N_PKTS);
    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(N_DATA - 1);

    if ((PAYLOAD_WIDTH % PACKET_WIDTH) != 0 || PAYLOAD_WIDTH < PACKET_WIDTH) begin : g_bad_width
        $error("PAYLOAD_WIDTH must be a non-zero multiple of PACKET_WIDTH");
    end

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     grant_q, grant_d;
    logic                     valid_q, valid_d;
    logic                     received_q, received_d;
    logic                     err_q, err_d;
    logic [1:0]               code_q, code_d;
    logic                     beat_en;
    logic [PAYLOAD_WIDTH-1:0] payload_q;

    // Next-state and control decode; grant is held from START through the last data beat
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        received_d = 1'b0;
        err_d      = err_q;
        code_d     = code_q;
        beat_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.packet_req_i && !valid_q) begin
                    grant_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bus.packet_i == START_WORD) begin
                    state_d = ST_HDR;
                end else begin
                    err_d   = 1'b1;
                    code_d  = err_q ? code_q : ERR_START;
                    grant_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (bus.packet_i == HDR_WORD) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    err_d   = 1'b1;
                    code_d  = err_q ? code_q : ERR_HDR;
                    grant_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                beat_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    grant_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (valid_q && bus.payload_ready_i) begin
                    valid_d    = 1'b0;
                    received_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_q    <= 1'b0;
            valid_q    <= 1'b0;
            received_q <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            received_q <= received_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    // Payload assembly, LSB packet first; untouched outside DATA so it is stable in HOLD
    always_ff @(posedge clk) begin
        if (reset) begin
            payload_q <= '0;
        end else if (beat_en) begin
            payload_q[int'(cnt_q)*PACKET_WIDTH +: PACKET_WIDTH] <= bus.packet_i;
        end
    end

    assign bus.packet_grant_o    = grant_q;
    assign bus.payload_valid_o   = valid_q;
    assign bus.payload_o         = payload_q;
    assign bus.packet_received_o = received_q;
    assign err_o                 = err_q;
    assign err_code_o            = code_q;

endmodule

// File: tb/tb_packet_depacketizer_sc.sv
// tb/tb_packet_depacketizer_sc.sv - scoreboard bench for packet_depacketizer_sc
module tb_packet_depacketizer_sc;

    localparam int PW = 512;
    localparam int KW = 16;
    localparam int ND = 32;
    localparam logic [15:0] START_OK = 16'h0001;
    localparam logic [15:0] HDR_OK   = 16'h0021;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       err;
    logic [1:0] err_code;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rx_count = 0;
    logic acc_pend = 1'b0;
    logic [PW-1:0] sb_q[$];

    packet_depacketizer_sc_if #(.PAYLOAD_WIDTH(PW), .PACKET_WIDTH(KW)) bus ();

    packet_depacketizer_sc #(.PAYLOAD_WIDTH(PW), .PACKET_WIDTH(KW), .ID(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .err_o      (err),
        .err_code_o (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [15:0] base);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < ND; k++) p[k*KW +: KW] = base + 16'(k);
        return p;
    endfunction

    // Output monitor: scoreboard pop on accept, one-cycle received pulse, no grant while valid
    always @(negedge clk) begin
        if (reset) begin
            acc_pend <= 1'b0;
        end else begin
            if (acc_pend || bus.packet_received_o)
                check("rx_pulse", PW'(bus.packet_received_o), PW'(acc_pend));
            if (bus.packet_received_o) rx_count <= rx_count + 1;
            if (bus.payload_valid_o)
                check("grant_while_valid", PW'(bus.packet_grant_o), PW'(0));
            if (bus.payload_valid_o && bus.payload_ready_i) begin
                if (sb_q.size() == 0) check("sb_unexpected", PW'(1), PW'(0));
                else check("payload", bus.payload_o, sb_q.pop_front());
            end
            acc_pend <= bus.payload_valid_o && bus.payload_ready_i;
        end
    end

    // Packetizer model: start, header, data beats; stops early on bad packets or abort_at
    task automatic send(input logic [15:0] sw, input logic [15:0] hw, input logic [15:0] base,
                        input int abort_at, input logic drop_req, input logic [1:0] exp_code,
                        output int waited);
        bit good_start;
        bit good;
        good_start = (sw == START_OK);
        good = good_start && (hw == HDR_OK);
        waited = 0;
        bus.packet_req_i = 1'b1;
        while (!bus.packet_grant_o && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.packet_grant_o) begin
            check("grant_timeout", PW'(0), PW'(1));
            bus.packet_req_i = 1'b0;
            return;
        end
        if (good && abort_at < 0) sb_q.push_back(mk(base));
        bus.packet_i = sw;
        @(posedge clk); #1;
        if (!good_start) begin
            bus.packet_req_i = 1'b0;
            check("start_err", PW'(err), PW'(1));
            check("start_code", PW'(err_code), PW'(exp_code));
            check("start_grant_drop", PW'(bus.packet_grant_o), PW'(0));
            check("start_no_valid", PW'(bus.payload_valid_o), PW'(0));
            return;
        end
        check("grant_hdr", PW'(bus.packet_grant_o), PW'(1));
        bus.packet_i = hw;
        @(posedge clk); #1;
        if (hw != HDR_OK) begin
            bus.packet_req_i = 1'b0;
            check("hdr_err", PW'(err), PW'(1));
            check("hdr_code", PW'(err_code), PW'(exp_code));
            check("hdr_grant_drop", PW'(bus.packet_grant_o), PW'(0));
            check("hdr_no_valid", PW'(bus.payload_valid_o), PW'(0));
            return;
        end
        for (int k = 0; k < ND; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                bus.packet_req_i = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                check("rst_grant", PW'(bus.packet_grant_o), PW'(0));
                check("rst_valid", PW'(bus.payload_valid_o), PW'(0));
                check("rst_err", PW'(err), PW'(0));
                check("rst_code", PW'(err_code), PW'(0));
                return;
            end
            check("grant_data", PW'(bus.packet_grant_o), PW'(1));
            bus.packet_i = base + 16'(k);
            if (k == ND - 1 && drop_req) bus.packet_req_i = 1'b0;
            @(posedge clk); #1;
        end
        check("valid_rise", PW'(bus.payload_valid_o), PW'(1));
        check("grant_end", PW'(bus.packet_grant_o), PW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int c0;
        int rx0;
        logic [PW-1:0] hold_exp;
        bus.packet_req_i = 1'b0;
        bus.lock_i = 1'b0;
        bus.packet_i = '0;
        bus.payload_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant0", PW'(bus.packet_grant_o), PW'(0));
        check("rst_valid0", PW'(bus.payload_valid_o), PW'(0));
        check("rst_payload0", bus.payload_o, PW'(0));
        check("rst_rx0", PW'(bus.packet_received_o), PW'(0));
        check("rst_err0", PW'(err), PW'(0));
        check("rst_code0", PW'(err_code), PW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Normal transfer with latency
        bus.payload_ready_i = 1'b1;
        bus.lock_i = 1'b1;
        c0 = cyc;
        send(START_OK, HDR_OK, 16'h1000, -1, 1'b1, 2'd0, w);
        check("latency", PW'(cyc - c0), PW'(35));
        bus.lock_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rx_after_normal", PW'(rx_count), PW'(1));

        // Backpressure: valid held, payload stable, no grant, regrant after accept
        bus.payload_ready_i = 1'b0;
        send(START_OK, HDR_OK, 16'h2000, -1, 1'b0, 2'd0, w);
        hold_exp = mk(16'h2000);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid", PW'(bus.payload_valid_o), PW'(1));
            check("bp_payload", bus.payload_o, hold_exp);
        end
        bus.payload_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_accept_valid", PW'(bus.payload_valid_o), PW'(0));
        check("bp_accept_grant", PW'(bus.packet_grant_o), PW'(0));
        @(posedge clk); #1;
        check("bp_regrant", PW'(bus.packet_grant_o), PW'(1));
        send(START_OK, HDR_OK, 16'h3000, -1, 1'b1, 2'd0, w);
        repeat (3) @(posedge clk);
        #1;

        // Bad ID, then a clean transfer; error stays sticky
        send(16'h0003, HDR_OK, 16'h0, -1, 1'b1, 2'd1, w);
        repeat (3) begin
            @(posedge clk); #1;
            check("badid_no_valid", PW'(bus.payload_valid_o), PW'(0));
        end
        send(START_OK, HDR_OK, 16'h4000, -1, 1'b1, 2'd0, w);
        repeat (3) @(posedge clk);
        #1;
        check("sticky_err", PW'(err), PW'(1));
        check("sticky_code", PW'(err_code), PW'(1));

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("clr_err", PW'(err), PW'(0));

        // Bad header, then a bad start: first error code is kept
        send(START_OK, 16'h0020, 16'h0, -1, 1'b1, 2'd2, w);
        repeat (3) @(posedge clk);
        #1;
        send(16'h0003, HDR_OK, 16'h0, -1, 1'b1, 2'd2, w);
        repeat (3) @(posedge clk);
        #1;

        // Reset at data beat 10, then a fresh transfer
        send(START_OK, HDR_OK, 16'h0B00, 10, 1'b1, 2'd0, w);
        repeat (2) @(posedge clk);
        #1;
        send(START_OK, HDR_OK, 16'h5000, -1, 1'b1, 2'd0, w);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back with ready tied high
        rx0 = rx_count;
        send(START_OK, HDR_OK, 16'h6000, -1, 1'b1, 2'd0, w);
        send(START_OK, HDR_OK, 16'h7000, -1, 1'b1, 2'd0, w);
        check("b2b_gap1", PW'(w), PW'(2));
        send(START_OK, HDR_OK, 16'h8000, -1, 1'b1, 2'd0, w);
        check("b2b_gap2", PW'(w), PW'(2));
        repeat (4) @(posedge clk);
        #1;
        check("b2b_rx", PW'(rx_count - rx0), PW'(3));

        check("sb_drained", PW'(sb_q.size()), PW'(0));
        check("rx_total", PW'(rx_count), PW'(8));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
